// File: rtl/fsm_pkg.sv
// fsm_pkg: ring-FSM encodings, successor mapping and decoder states
package fsm_pkg;
  localparam int NUM_STATES = 5;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    RING_S0 = 3'd0,
    RING_S1 = 3'd1,
    RING_S2 = 3'd2,
    RING_S3 = 3'd3,
    RING_S4 = 3'd4
  } ring_state_e;
  typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} dec_state_e;
  function automatic logic [STATE_W-1:0] ring_next(input logic [STATE_W-1:0] s);
    return (s == RING_S4) ? RING_S0 : s + 3'd1;
  endfunction
  function automatic logic ring_legal(input logic [STATE_W-1:0] s);
    return s < STATE_W'(NUM_STATES);
  endfunction
endpackage

// File: rtl/fsm_next.sv
// fsm_next: combinational ring successor with legality flag
import fsm_pkg::*;
module fsm_next (
  input  logic [STATE_W-1:0] i_state,
  output logic [STATE_W-1:0] o_next,
  output logic               o_legal
);
  always_comb begin
    o_legal = ring_legal(i_state);
    o_next  = o_legal ? ring_next(i_state) : '0;
  end
endmodule

// File: rtl/fsm_decoder.sv
// fsm_decoder: recovers per-state advance enables of a 5-state ring from its sampled state stream
import fsm_pkg::*;
module fsm_decoder #(
  parameter int LAP_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [STATE_W-1:0]    state,
  output logic                  out_valid,
  output logic [NUM_STATES-1:0] adv,
  output logic                  hold,
  output logic                  err,
  output logic                  err_seen,
  output logic [LAP_W-1:0]      laps
);
  dec_state_e                r_fsm, w_fsm_nx;
  logic [STATE_W-1:0]        r_prev, w_prev_nx, w_succ;
  logic                      w_prev_legal, w_legal, w_ov, w_hold, w_err, w_step;
  logic [NUM_STATES-1:0]     w_adv;
  fsm_next u_next (
    .i_state(r_prev),
    .o_next (w_succ),
    .o_legal(w_prev_legal)
  );
  always_comb begin
    w_legal   = ring_legal(state);
    w_fsm_nx  = r_fsm;
    w_prev_nx = r_prev;
    w_ov      = 1'b0;
    w_adv     = '0;
    w_hold    = 1'b0;
    w_err     = 1'b0;
    w_step    = w_prev_legal && state == w_succ;
    if (in_valid && r_fsm == EMPTY) begin
      w_ov      = !w_legal;
      w_err     = !w_legal;
      w_fsm_nx  = w_legal ? TRACK : EMPTY;
      w_prev_nx = w_legal ? state : r_prev;
    end else if (in_valid) begin
      w_ov      = 1'b1;
      w_hold    = w_legal && state == r_prev;
      w_adv     = (w_legal && w_step) ? NUM_STATES'(1) << r_prev : '0;
      w_err     = !w_hold && !(w_legal && w_step);
      w_fsm_nx  = w_legal ? TRACK : EMPTY;
      w_prev_nx = w_legal ? state : r_prev;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm     <= EMPTY;
      r_prev    <= '0;
      out_valid <= 1'b0;
      adv       <= '0;
      hold      <= 1'b0;
      err       <= 1'b0;
      err_seen  <= 1'b0;
      laps      <= '0;
    end else begin
      r_fsm     <= w_fsm_nx;
      r_prev    <= w_prev_nx;
      out_valid <= w_ov;
      adv       <= w_adv;
      hold      <= w_hold;
      err       <= w_err;
      err_seen  <= err_seen | w_err;
      laps      <= laps + LAP_W'(w_adv[NUM_STATES-1]);
    end
  end
endmodule
